// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: round-robin sharing of one modexp engine among NUM_REQ requesters with watchdog and valid/ready result return
module rsa_job_arbiter #(
  parameter int WIDTH = 64,
  parameter int E_BITS = 64,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WIDTH-1:0]      req_m,
  input  logic [NUM_REQ*E_BITS-1:0]     req_e,
  input  logic [NUM_REQ*WIDTH-1:0]      req_n,
  input  logic [NUM_REQ*WIDTH-1:0]      req_ninv,
  input  logic [NUM_REQ*WIDTH-1:0]      req_r2,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [WIDTH-1:0]              rsp_c,
  output logic                          rsp_err,
  output logic                          eng_rst,
  output logic                          eng_start,
  output logic [WIDTH-1:0]              eng_m,
  output logic [WIDTH-1:0]              eng_n,
  output logic [WIDTH-1:0]              eng_ninv,
  output logic [WIDTH-1:0]              eng_r2,
  output logic [E_BITS-1:0]             eng_e,
  input  logic [WIDTH-1:0]              eng_c,
  input  logic                          eng_done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);
  localparam int OW = $clog2(NUM_REQ);
  localparam logic [19:0] TO = 20'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [OW-1:0] ptr, win, idx;
  logic found, done_ok, tmo;
  logic [19:0] cnt;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = OW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    done_ok = state == WAIT && cnt != '0 && eng_done;
    tmo = state == WAIT && !done_ok && cnt == TO - 20'd1;
    state_nx = state == IDLE  ? (found ? START : IDLE)
             : state == START ? WAIT
             : state == WAIT  ? (done_ok || tmo ? RESP : WAIT)
             : (rsp_ready[owner] ? IDLE : RESP);
    gnt = state == START ? ONE << owner : '0;
    rsp_valid = state == RESP ? ONE << owner : '0;
    eng_start = state == START;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      rsp_c <= '0;
      rsp_err <= 1'b0;
      eng_rst <= 1'b1;
      eng_m <= '0;
      eng_e <= '0;
      eng_n <= '0;
      eng_ninv <= '0;
      eng_r2 <= '0;
    end else begin
      eng_rst <= tmo;
      cnt <= state == WAIT ? cnt + 20'd1 : '0;
      if (state == IDLE && found) begin
        owner <= win;
        ptr <= win == OW'(NUM_REQ - 1) ? '0 : win + 1'b1;
        eng_m <= req_m[int'(win)*WIDTH +: WIDTH];
        eng_e <= req_e[int'(win)*E_BITS +: E_BITS];
        eng_n <= req_n[int'(win)*WIDTH +: WIDTH];
        eng_ninv <= req_ninv[int'(win)*WIDTH +: WIDTH];
        eng_r2 <= req_r2[int'(win)*WIDTH +: WIDTH];
      end
      if (done_ok) begin
        rsp_c <= eng_c;
        rsp_err <= 1'b0;
      end
      if (tmo) begin
        rsp_c <= '0;
        rsp_err <= 1'b1;
      end
    end
endmodule
